// File: rtl/zic_active_ctrl_if.sv
// Core-side and ZIC-side handshake bundle for the claim/EOI controller.
// The controller takes the slave view; the environment takes the master view.
interface zic_active_ctrl_if #(
  parameter int DEPTH = 8,
  parameter int IDW   = 8,
  parameter int LPW   = 8,
  parameter int DW    = $clog2(DEPTH + 1)
);
  logic           interrupt_request_i;
  logic           interrupt_id_valid_i;
  logic [IDW-1:0] interrupt_id_i;
  logic [LPW-1:0] req_lvl_pr_i;
  logic           core_claim_i;
  logic           core_eoi_i;
  logic           zic_ack_o;
  logic [IDW-1:0] zic_ack_id_o;
  logic           zic_eoi_valid_o;
  logic [LPW-1:0] active_lvl_pr_o;
  logic [IDW-1:0] active_id_o;
  logic [DW-1:0]  nest_depth_o;
  logic           stack_full_o;
  logic           overflow_err_o;
  logic           underflow_err_o;

  modport slave (
    input  interrupt_request_i, interrupt_id_valid_i, interrupt_id_i, req_lvl_pr_i,
           core_claim_i, core_eoi_i,
    output zic_ack_o, zic_ack_id_o, zic_eoi_valid_o, active_lvl_pr_o, active_id_o,
           nest_depth_o, stack_full_o, overflow_err_o, underflow_err_o
  );

  modport master (
    output interrupt_request_i, interrupt_id_valid_i, interrupt_id_i, req_lvl_pr_i,
           core_claim_i, core_eoi_i,
    input  zic_ack_o, zic_ack_id_o, zic_eoi_valid_o, active_lvl_pr_o, active_id_o,
           nest_depth_o, stack_full_o, overflow_err_o, underflow_err_o
  );
endinterface

// File: rtl/zic_active_ctrl.sv
// Interrupt claim/completion controller: latches the ZIC offer, generates ack/EOI
// pulses and keeps a nesting stack so preempted handlers resume at their level.
module zic_active_ctrl #(
  parameter int DEPTH = 8,
  parameter int IDW   = 8,
  parameter int LPW   = 8
) (
  input  logic             zic_clk,
  input  logic             zic_rst,
  input  logic             wdt_reset_i,
  zic_active_ctrl_if.slave bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = IDW + LPW;
  localparam logic [DW-1:0] DEPTH_C = DW'(DEPTH);
  localparam logic [DW-1:0] ONE_C   = DW'(1);

  logic [EW-1:0]  stack_q [DEPTH];

  logic           offer_v_q, offer_v_d;
  logic [IDW-1:0] offer_id_q, offer_id_d;
  logic [LPW-1:0] offer_lp_q, offer_lp_d;
  logic [IDW-1:0] act_id_q, act_id_d;
  logic [LPW-1:0] act_lp_q, act_lp_d;
  logic [DW-1:0]  depth_q, depth_d;
  logic           ack_q, ack_d;
  logic [IDW-1:0] ack_id_q, ack_id_d;
  logic           eoi_q, eoi_d;
  logic           full_q, full_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;

  logic           reset_s;
  logic           claim_ok_s;
  logic           push_s;
  logic           tail_s;
  logic           empty_s;
  logic           full_s;
  logic [AW-1:0]  top_idx_s;
  logic [EW-1:0]  top_s;

  // Next-state decode: tail-chain, push, pop, and the two error conditions.
  always_comb begin
    reset_s    = ~zic_rst | wdt_reset_i;
    claim_ok_s = bus.core_claim_i & offer_v_q;
    empty_s    = (depth_q == {DW{1'b0}});
    full_s     = (depth_q == DEPTH_C);
    if (empty_s) begin
      top_idx_s = {AW{1'b0}};
    end else begin
      top_idx_s = AW'(depth_q - ONE_C);
    end
    top_s      = stack_q[top_idx_s];

    push_s     = 1'b0;
    tail_s     = 1'b0;
    act_id_d   = act_id_q;
    act_lp_d   = act_lp_q;
    depth_d    = depth_q;
    ack_d      = 1'b0;
    ack_id_d   = ack_id_q;
    eoi_d      = 1'b0;
    ovf_d      = ovf_q;
    unf_d      = unf_q;

    if (claim_ok_s && bus.core_eoi_i) begin
      if (empty_s) begin
        unf_d  = 1'b1;
        push_s = 1'b1;
      end else begin
        tail_s = 1'b1;
        eoi_d  = 1'b1;
      end
    end else if (claim_ok_s) begin
      if (full_s) begin
        ovf_d = 1'b1;
      end else begin
        push_s = 1'b1;
      end
    end else if (bus.core_eoi_i) begin
      if (empty_s) begin
        unf_d = 1'b1;
      end else begin
        eoi_d   = 1'b1;
        depth_d = depth_q - ONE_C;
        // Landing on depth 0 means idle, whatever the bottom slot holds.
        if (depth_q == ONE_C) begin
          act_id_d = {IDW{1'b0}};
          act_lp_d = {LPW{1'b0}};
        end else begin
          act_id_d = top_s[EW-1:LPW];
          act_lp_d = top_s[LPW-1:0];
        end
      end
    end else begin
      depth_d = depth_q;
    end

    if (push_s || tail_s) begin
      act_id_d = offer_id_q;
      act_lp_d = offer_lp_q;
      ack_d    = 1'b1;
      ack_id_d = offer_id_q;
    end else begin
      ack_id_d = ack_id_q;
    end
    if (push_s) begin
      depth_d = depth_q + ONE_C;
    end else begin
      depth_d = depth_d;
    end
    full_d = (depth_d == DEPTH_C);

    offer_id_d = offer_id_q;
    offer_lp_d = offer_lp_q;
    if (bus.interrupt_request_i && bus.interrupt_id_valid_i) begin
      offer_v_d  = 1'b1;
      offer_id_d = bus.interrupt_id_i;
      offer_lp_d = bus.req_lvl_pr_i;
    end else if (!bus.interrupt_request_i || push_s || tail_s) begin
      offer_v_d = 1'b0;
    end else begin
      offer_v_d = offer_v_q;
    end
  end

  // Control and output registers with synchronous reset (rst low or watchdog).
  always_ff @(posedge zic_clk) begin
    if (!zic_rst || wdt_reset_i) begin
      offer_v_q  <= 1'b0;
      offer_id_q <= {IDW{1'b0}};
      offer_lp_q <= {LPW{1'b0}};
      act_id_q   <= {IDW{1'b0}};
      act_lp_q   <= {LPW{1'b0}};
      depth_q    <= {DW{1'b0}};
      ack_q      <= 1'b0;
      ack_id_q   <= {IDW{1'b0}};
      eoi_q      <= 1'b0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      offer_v_q  <= offer_v_d;
      offer_id_q <= offer_id_d;
      offer_lp_q <= offer_lp_d;
      act_id_q   <= act_id_d;
      act_lp_q   <= act_lp_d;
      depth_q    <= depth_d;
      ack_q      <= ack_d;
      ack_id_q   <= ack_id_d;
      eoi_q      <= eoi_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Stack slots are write-only on push; stale entries above depth are don't-care.
  always_ff @(posedge zic_clk) begin
    if (push_s && !reset_s) begin
      stack_q[AW'(depth_q)] <= {act_id_q, act_lp_q};
    end else begin
      stack_q <= stack_q;
    end
  end

  assign bus.zic_ack_o       = ack_q;
  assign bus.zic_ack_id_o    = ack_id_q;
  assign bus.zic_eoi_valid_o = eoi_q;
  assign bus.active_lvl_pr_o = act_lp_q;
  assign bus.active_id_o     = act_id_q;
  assign bus.nest_depth_o    = depth_q;
  assign bus.stack_full_o    = full_q;
  assign bus.overflow_err_o  = ovf_q;
  assign bus.underflow_err_o = unf_q;
endmodule

// File: tb/tb_zic_active_ctrl.sv
// Bench for zic_active_ctrl: directed scenarios plus randomized traffic checked
// against a queue-based model of the claim/EOI rules.
module tb_zic_active_ctrl;
  localparam int DEPTH = 8;

  logic zic_clk = 1'b0;
  logic zic_rst = 1'b0;
  logic wdt_reset_i = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  zic_active_ctrl_if #(.DEPTH(DEPTH), .IDW(8), .LPW(8)) bus ();

  zic_active_ctrl #(.DEPTH(DEPTH), .IDW(8), .LPW(8)) dut (
    .zic_clk     (zic_clk),
    .zic_rst     (zic_rst),
    .wdt_reset_i (wdt_reset_i),
    .bus         (bus)
  );

  always #5 zic_clk = ~zic_clk;

  // Reference model state
  logic [15:0] m_stack [$];
  logic [7:0]  m_act_id, m_act_lp, m_ack_id, m_oid, m_olp;
  bit          m_ov, m_ack, m_eoi, m_ovf, m_unf;

  task automatic model_step(input bit req, input bit idv, input logic [7:0] id,
                            input logic [7:0] lp, input bit claim, input bit eoi, input bit rst);
    bit cv, took;
    if (rst) begin
      m_stack.delete();
      m_act_id = 8'h00; m_act_lp = 8'h00; m_ack_id = 8'h00; m_oid = 8'h00; m_olp = 8'h00;
      m_ov = 1'b0; m_ack = 1'b0; m_eoi = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      cv = claim && m_ov;
      took = 1'b0;
      m_ack = 1'b0;
      m_eoi = 1'b0;
      if (eoi && m_stack.size() == 0) m_unf = 1'b1;
      if (cv && eoi && m_stack.size() > 0) begin
        took = 1'b1;
        m_eoi = 1'b1;
      end else if (cv) begin
        if (m_stack.size() >= DEPTH) m_ovf = 1'b1;
        else begin
          m_stack.push_back({m_act_id, m_act_lp});
          took = 1'b1;
        end
      end else if (eoi && m_stack.size() > 0) begin
        {m_act_id, m_act_lp} = m_stack.pop_back();
        m_eoi = 1'b1;
      end
      if (took) begin
        m_act_id = m_oid; m_act_lp = m_olp; m_ack = 1'b1; m_ack_id = m_oid;
      end
      if (req && idv) begin
        m_ov = 1'b1; m_oid = id; m_olp = lp;
      end else if (!req || took) begin
        m_ov = 1'b0;
      end
    end
  endtask

  // Apply one cycle of stimulus to DUT and model; outputs are stable on return.
  task automatic drive(input bit req, input bit idv, input logic [7:0] id, input logic [7:0] lp,
                       input bit claim, input bit eoi, input bit wdt);
    bus.interrupt_request_i  = req;
    bus.interrupt_id_valid_i = idv;
    bus.interrupt_id_i       = id;
    bus.req_lvl_pr_i         = lp;
    bus.core_claim_i         = claim;
    bus.core_eoi_i           = eoi;
    wdt_reset_i              = wdt;
    model_step(req, idv, id, lp, claim, eoi, wdt || !zic_rst);
    @(posedge zic_clk);
    #1;
  endtask

  task automatic do_reset();
    zic_rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    zic_rst = 1'b1;
  endtask

  task automatic claim_one(input logic [7:0] id, input logic [7:0] lp);
    drive(1'b1, 1'b1, id, lp, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic eoi_one();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.zic_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset.ack got=%0h exp=0", bus.zic_ack_o); end
    n_cmp++; if (bus.zic_ack_id_o !== 8'h00) begin n_fail++; $display("FAIL reset.ack_id got=%0h exp=0", bus.zic_ack_id_o); end
    n_cmp++; if (bus.zic_eoi_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset.eoi got=%0h exp=0", bus.zic_eoi_valid_o); end
    n_cmp++; if (bus.active_lvl_pr_o !== 8'h00) begin n_fail++; $display("FAIL reset.lp got=%0h exp=0", bus.active_lvl_pr_o); end
    n_cmp++; if (bus.active_id_o !== 8'h00) begin n_fail++; $display("FAIL reset.id got=%0h exp=0", bus.active_id_o); end
    n_cmp++; if (bus.nest_depth_o !== 4'd0) begin n_fail++; $display("FAIL reset.depth got=%0d exp=0", bus.nest_depth_o); end
    n_cmp++; if (bus.stack_full_o !== 1'b0) begin n_fail++; $display("FAIL reset.full got=%0h exp=0", bus.stack_full_o); end
    n_cmp++; if ({bus.overflow_err_o, bus.underflow_err_o} !== 2'b00) begin n_fail++; $display("FAIL reset.errs got=%0b exp=00", {bus.overflow_err_o, bus.underflow_err_o}); end
  endtask

  task automatic test_single();
    do_reset();
    claim_one(8'd5, 8'h40);
    n_cmp++; if (bus.zic_ack_o !== 1'b1) begin n_fail++; $display("FAIL single.ack got=%0h exp=1", bus.zic_ack_o); end
    n_cmp++; if (bus.zic_ack_id_o !== 8'd5) begin n_fail++; $display("FAIL single.ack_id got=%0d exp=5", bus.zic_ack_id_o); end
    n_cmp++; if ({bus.active_lvl_pr_o, bus.active_id_o} !== {8'h40, 8'd5}) begin n_fail++; $display("FAIL single.active got=%0h/%0d exp=40/5", bus.active_lvl_pr_o, bus.active_id_o); end
    n_cmp++; if (bus.nest_depth_o !== 4'd1) begin n_fail++; $display("FAIL single.depth got=%0d exp=1", bus.nest_depth_o); end
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.zic_ack_o !== 1'b0) begin n_fail++; $display("FAIL single.ack_width got=%0h exp=0", bus.zic_ack_o); end
    n_cmp++; if (bus.zic_ack_id_o !== 8'd5) begin n_fail++; $display("FAIL single.ack_id_hold got=%0d exp=5", bus.zic_ack_id_o); end
    eoi_one();
    n_cmp++; if (bus.zic_eoi_valid_o !== 1'b1) begin n_fail++; $display("FAIL single.eoi got=%0h exp=1", bus.zic_eoi_valid_o); end
    n_cmp++; if ({bus.active_lvl_pr_o, bus.active_id_o, bus.nest_depth_o} !== {8'h00, 8'h00, 4'd0}) begin n_fail++; $display("FAIL single.idle got=%0h/%0d/%0d exp=0/0/0", bus.active_lvl_pr_o, bus.active_id_o, bus.nest_depth_o); end
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.zic_eoi_valid_o !== 1'b0) begin n_fail++; $display("FAIL single.eoi_width got=%0h exp=0", bus.zic_eoi_valid_o); end
  endtask

  task automatic test_nest3();
    logic [7:0] ids [3] = '{8'd3, 8'd7, 8'd9};
    logic [7:0] lps [3] = '{8'h20, 8'h50, 8'h90};
    do_reset();
    for (int i = 0; i < 3; i++) claim_one(ids[i], lps[i]);
    n_cmp++; if (bus.nest_depth_o !== 4'd3) begin n_fail++; $display("FAIL nest3.depth got=%0d exp=3", bus.nest_depth_o); end
    for (int k = 0; k < 3; k++) begin
      logic [7:0] eid, elp;
      eid = (k == 2) ? 8'h00 : ids[1 - k];
      elp = (k == 2) ? 8'h00 : lps[1 - k];
      eoi_one();
      n_cmp++; if ({bus.zic_eoi_valid_o, bus.active_lvl_pr_o, bus.active_id_o} !== {1'b1, elp, eid}) begin n_fail++; $display("FAIL nest3.unwind%0d got=%0h/%0h/%0d exp=1/%0h/%0d", k, bus.zic_eoi_valid_o, bus.active_lvl_pr_o, bus.active_id_o, elp, eid); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++) claim_one(8'(i + 1), 8'((i + 1) * 16));
    n_cmp++; if (bus.stack_full_o !== 1'b1) begin n_fail++; $display("FAIL ovf.full_at8 got=%0h exp=1", bus.stack_full_o); end
    claim_one(8'd9, 8'h99);
    n_cmp++; if (bus.zic_ack_o !== 1'b0) begin n_fail++; $display("FAIL ovf.no_ack got=%0h exp=0", bus.zic_ack_o); end
    n_cmp++; if (bus.overflow_err_o !== 1'b1) begin n_fail++; $display("FAIL ovf.flag got=%0h exp=1", bus.overflow_err_o); end
    n_cmp++; if ({bus.nest_depth_o, bus.stack_full_o} !== {4'd8, 1'b1}) begin n_fail++; $display("FAIL ovf.depth got=%0d/%0h exp=8/1", bus.nest_depth_o, bus.stack_full_o); end
    n_cmp++; if (bus.active_id_o !== 8'd8) begin n_fail++; $display("FAIL ovf.active got=%0d exp=8", bus.active_id_o); end
    for (int k = 1; k <= DEPTH; k++) begin
      logic [7:0] eid, elp;
      eid = (k == DEPTH) ? 8'h00 : 8'(8 - k);
      elp = (k == DEPTH) ? 8'h00 : 8'((8 - k) * 16);
      eoi_one();
      n_cmp++; if ({bus.zic_eoi_valid_o, bus.active_lvl_pr_o, bus.active_id_o, bus.nest_depth_o} !== {1'b1, elp, eid, 4'(DEPTH - k)}) begin n_fail++; $display("FAIL ovf.unwind%0d got=%0h/%0h/%0d/%0d exp=1/%0h/%0d/%0d", k, bus.zic_eoi_valid_o, bus.active_lvl_pr_o, bus.active_id_o, bus.nest_depth_o, elp, eid, DEPTH - k); end
    end
    n_cmp++; if ({bus.overflow_err_o, bus.stack_full_o} !== 2'b10) begin n_fail++; $display("FAIL ovf.sticky got=%0b exp=10", {bus.overflow_err_o, bus.stack_full_o}); end
  endtask

  task automatic test_underflow_spurious();
    do_reset();
    eoi_one();
    n_cmp++; if (bus.underflow_err_o !== 1'b1) begin n_fail++; $display("FAIL unf.flag got=%0h exp=1", bus.underflow_err_o); end
    n_cmp++; if (bus.zic_eoi_valid_o !== 1'b0) begin n_fail++; $display("FAIL unf.no_eoi got=%0h exp=0", bus.zic_eoi_valid_o); end
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if ({bus.zic_ack_o, bus.nest_depth_o, bus.active_id_o, bus.overflow_err_o} !== {1'b0, 4'd0, 8'h00, 1'b0}) begin n_fail++; $display("FAIL spurious.claim got=%0h/%0d/%0d/%0h exp=0/0/0/0", bus.zic_ack_o, bus.nest_depth_o, bus.active_id_o, bus.overflow_err_o); end
    n_cmp++; if (bus.underflow_err_o !== 1'b1) begin n_fail++; $display("FAIL unf.sticky got=%0h exp=1", bus.underflow_err_o); end
  endtask

  task automatic test_tail_chain();
    do_reset();
    claim_one(8'd2, 8'h10);
    claim_one(8'd4, 8'h30);
    drive(1'b1, 1'b1, 8'd6, 8'h60, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    n_cmp++; if ({bus.zic_ack_o, bus.zic_eoi_valid_o} !== 2'b11) begin n_fail++; $display("FAIL tail.pulses got=%0b exp=11", {bus.zic_ack_o, bus.zic_eoi_valid_o}); end
    n_cmp++; if ({bus.active_lvl_pr_o, bus.active_id_o, bus.zic_ack_id_o} !== {8'h60, 8'd6, 8'd6}) begin n_fail++; $display("FAIL tail.active got=%0h/%0d/%0d exp=60/6/6", bus.active_lvl_pr_o, bus.active_id_o, bus.zic_ack_id_o); end
    n_cmp++; if ({bus.nest_depth_o, bus.underflow_err_o} !== {4'd2, 1'b0}) begin n_fail++; $display("FAIL tail.depth got=%0d/%0h exp=2/0", bus.nest_depth_o, bus.underflow_err_o); end
    eoi_one();
    n_cmp++; if ({bus.active_lvl_pr_o, bus.active_id_o, bus.nest_depth_o} !== {8'h10, 8'd2, 4'd1}) begin n_fail++; $display("FAIL tail.below got=%0h/%0d/%0d exp=10/2/1", bus.active_lvl_pr_o, bus.active_id_o, bus.nest_depth_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) claim_one(8'(i + 10), 8'(i * 32 + 32));
    zic_rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    zic_rst = 1'b1;
    n_cmp++; if ({bus.zic_eoi_valid_o, bus.active_lvl_pr_o, bus.active_id_o, bus.nest_depth_o, bus.zic_ack_id_o} !== {1'b0, 8'h00, 8'h00, 4'd0, 8'h00}) begin n_fail++; $display("FAIL rstmid.outputs got=%0h/%0h/%0d/%0d/%0d exp=0/0/0/0/0", bus.zic_eoi_valid_o, bus.active_lvl_pr_o, bus.active_id_o, bus.nest_depth_o, bus.zic_ack_id_o); end
    for (int i = 0; i < 3; i++) claim_one(8'(i + 20), 8'(i * 16 + 16));
    drive(1'b1, 1'b1, 8'd30, 8'hF0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    n_cmp++; if ({bus.zic_ack_o, bus.nest_depth_o, bus.active_id_o, bus.zic_ack_id_o} !== {1'b0, 4'd0, 8'h00, 8'h00}) begin n_fail++; $display("FAIL rstmid.wdt got=%0h/%0d/%0d/%0d exp=0/0/0/0", bus.zic_ack_o, bus.nest_depth_o, bus.active_id_o, bus.zic_ack_id_o); end
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus.zic_ack_o !== 1'b0) begin n_fail++; $display("FAIL rstmid.offer_gone got=%0h exp=0", bus.zic_ack_o); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      bit req, idv, cl, eo, wdt;
      req = ($urandom_range(0, 99) < 80);
      idv = ($urandom_range(0, 99) < 60);
      cl  = ($urandom_range(0, 99) < 50);
      eo  = ($urandom_range(0, 99) < ((c < 400) ? 12 : 45));
      wdt = ($urandom_range(0, 199) == 0);
      zic_rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      drive(req, idv, 8'($urandom), 8'($urandom), cl, eo, wdt);
      n_cmp++; if (bus.zic_ack_o !== m_ack) begin n_fail++; $display("FAIL rand%0d.ack got=%0h exp=%0h", c, bus.zic_ack_o, m_ack); end
      n_cmp++; if (bus.zic_ack_id_o !== m_ack_id) begin n_fail++; $display("FAIL rand%0d.ack_id got=%0h exp=%0h", c, bus.zic_ack_id_o, m_ack_id); end
      n_cmp++; if (bus.zic_eoi_valid_o !== m_eoi) begin n_fail++; $display("FAIL rand%0d.eoi got=%0h exp=%0h", c, bus.zic_eoi_valid_o, m_eoi); end
      n_cmp++; if ({bus.active_lvl_pr_o, bus.active_id_o} !== {m_act_lp, m_act_id}) begin n_fail++; $display("FAIL rand%0d.active got=%0h/%0h exp=%0h/%0h", c, bus.active_lvl_pr_o, bus.active_id_o, m_act_lp, m_act_id); end
      n_cmp++; if (bus.nest_depth_o !== 4'(m_stack.size())) begin n_fail++; $display("FAIL rand%0d.depth got=%0d exp=%0d", c, bus.nest_depth_o, m_stack.size()); end
      n_cmp++; if (bus.stack_full_o !== (m_stack.size() == DEPTH)) begin n_fail++; $display("FAIL rand%0d.full got=%0h exp=%0h", c, bus.stack_full_o, m_stack.size() == DEPTH); end
      n_cmp++; if ({bus.overflow_err_o, bus.underflow_err_o} !== {m_ovf, m_unf}) begin n_fail++; $display("FAIL rand%0d.errs got=%0b exp=%0b", c, {bus.overflow_err_o, bus.underflow_err_o}, {m_ovf, m_unf}); end
    end
    zic_rst = 1'b1;
  endtask

  initial begin
    bus.interrupt_request_i  = 1'b0;
    bus.interrupt_id_valid_i = 1'b0;
    bus.interrupt_id_i       = 8'h00;
    bus.req_lvl_pr_i         = 8'h00;
    bus.core_claim_i         = 1'b0;
    bus.core_eoi_i           = 1'b0;
    test_reset();
    test_single();
    test_nest3();
    test_overflow();
    test_underflow_spurious();
    test_tail_chain();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
